// File: rtl/lab4_net_router_ctrl_if.sv
// Head-of-queue requests, crossbar selects and output handshakes between the router datapath and its route/switch controller.
// The controller takes the master modport; the datapath (input queues, crossbar) takes the slave modport.
interface lab4_net_router_ctrl_if #(
    parameter int p_srcdest_nbits = 3
);
    logic                       in0_val;
    logic                       in1_val;
    logic                       in2_val;
    logic [p_srcdest_nbits-1:0] in0_dest;
    logic [p_srcdest_nbits-1:0] in1_dest;
    logic [p_srcdest_nbits-1:0] in2_dest;
    logic                       in0_deq;
    logic                       in1_deq;
    logic                       in2_deq;
    logic                       out0_val;
    logic                       out1_val;
    logic                       out2_val;
    logic                       out0_rdy;
    logic                       out1_rdy;
    logic                       out2_rdy;
    logic [1:0]                 out0_sel;
    logic [1:0]                 out1_sel;
    logic [1:0]                 out2_sel;

    modport master (
        input  in0_val, in1_val, in2_val,
        input  in0_dest, in1_dest, in2_dest,
        input  out0_rdy, out1_rdy, out2_rdy,
        output in0_deq, in1_deq, in2_deq,
        output out0_val, out1_val, out2_val,
        output out0_sel, out1_sel, out2_sel
    );

    modport slave (
        output in0_val, in1_val, in2_val,
        output in0_dest, in1_dest, in2_dest,
        output out0_rdy, out1_rdy, out2_rdy,
        input  in0_deq, in1_deq, in2_deq,
        input  out0_val, out1_val, out2_val,
        input  out0_sel, out1_sel, out2_sel
    );
endinterface

// File: rtl/lab4_net_router_ctrl.sv
// Ring-router route compute plus per-output round-robin switch allocation; zero-cycle request-to-deq latency.
// Under backpressure (out_rdy=0) the grant and its pointer hold, so the same input stays selected until it transfers.
module lab4_net_router_ctrl #(
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    lab4_net_router_ctrl_if.master     bus
);
    localparam int NB = p_srcdest_nbits;
    localparam logic [NB:0]   ID_W  = p_router_id[NB:0];
    localparam logic [NB:0]   NUM_W = p_num_routers[NB:0];
    localparam logic [NB+1:0] NUM_X = {1'b0, NUM_W};

    logic [2:0]    val;
    logic [2:0]    rdy;
    logic [NB-1:0] dest [3];

    logic [1:0]    ptr_q [3];
    logic          tie_q;

    logic [NB:0]   fwd [3];
    logic [1:0]    route [3];
    logic [2:0]    is_tie;

    logic [2:0]    gnt_vld;
    logic [1:0]    gnt [3];
    logic [2:0]    deq;
    logic [1:0]    sel [3];

    assign val     = {bus.in2_val, bus.in1_val, bus.in0_val};
    assign rdy     = {bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};
    assign dest[0] = bus.in0_dest;
    assign dest[1] = bus.in1_dest;
    assign dest[2] = bus.in2_dest;

    // Clockwise hop count (fwd) decides direction; exactly half-way round is a tie
    // broken by tie_q, shared by all inputs in the same cycle.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            route[k]  = 2'd1;
            is_tie[k] = 1'b0;
            if ({1'b0, dest[k]} >= ID_W)
                fwd[k] = {1'b0, dest[k]} - ID_W;
            else
                fwd[k] = {1'b0, dest[k]} + NUM_W - ID_W;

            if (fwd[k] == '0)
                route[k] = 2'd1;
            else if ({fwd[k], 1'b0} < NUM_X)
                route[k] = 2'd2;
            else if ({fwd[k], 1'b0} > NUM_X)
                route[k] = 2'd0;
            else begin
                is_tie[k] = 1'b1;
                route[k]  = tie_q ? 2'd0 : 2'd2;
            end
        end
    end

    always_comb begin
        int idx;
        gnt_vld = '0;
        deq     = '0;
        idx     = 0;
        for (int j = 0; j < 3; j++) begin
            gnt[j] = 2'd0;
            for (int off = 0; off < 3; off++) begin
                idx = int'(ptr_q[j]) + off;
                if (idx >= 3)
                    idx = idx - 3;
                if (!gnt_vld[j] && val[idx] && route[idx] == 2'(j)) begin
                    gnt_vld[j] = 1'b1;
                    gnt[j]     = 2'(idx);
                end
            end
            if (!reset)
                gnt_vld[j] = 1'b0;
            sel[j] = gnt_vld[j] ? gnt[j] : 2'd3;
            if (gnt_vld[j] && rdy[j])
                deq[gnt[j]] = 1'b1;
        end
    end

    assign bus.out0_val = gnt_vld[0];
    assign bus.out1_val = gnt_vld[1];
    assign bus.out2_val = gnt_vld[2];
    assign bus.out0_sel = sel[0];
    assign bus.out1_sel = sel[1];
    assign bus.out2_sel = sel[2];
    assign bus.in0_deq  = deq[0];
    assign bus.in1_deq  = deq[1];
    assign bus.in2_deq  = deq[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < 3; j++)
                ptr_q[j] <= 2'd0;
            tie_q <= 1'b0;
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (gnt_vld[j] && rdy[j])
                    ptr_q[j] <= (gnt[j] == 2'd2) ? 2'd0 : gnt[j] + 2'd1;
            end
            if (|(deq & is_tie))
                tie_q <= ~tie_q;
        end
    end
endmodule
